// File: rtl/frustum_cull.sv
// rtl/frustum_cull.sv - clip-space triangle assembly, frustum outcode culling and triangle FIFO
module frustum_cull #(
    parameter int DEPTH      = 4,
    parameter int ATTR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [3:0][31:0]      vertex_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic [1:0]            mode_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [3:0][31:0]      vertex_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  last_out,
    output logic [15:0]           culled_count_out
);
    localparam int PW = $clog2(DEPTH);

    // Bits 0-5 are the six plane tests, bit 6 flags a vertex behind the eye or carrying a NaN.
    function automatic logic [6:0] outcode(input logic [3:0][31:0] v);
        logic [6:0]  oc;
        logic [30:0] wm;
        logic        nan;
        wm  = v[3][30:0];
        nan = 1'b0;
        for (int i = 0; i < 3; i++) begin
            oc[2*i]   = !v[i][31] && (v[i][30:0] > wm);
            oc[2*i+1] =  v[i][31] && (v[i][30:0] > wm);
        end
        for (int i = 0; i < 4; i++) begin
            nan = nan | ((v[i][30:23] == 8'hFF) && (v[i][22:0] != 23'd0));
        end
        oc[6] = v[3][31] || (wm == 31'd0) || nan;
        return oc;
    endfunction

    logic [1:0]            idx;
    logic [1:0]            mode_q;
    logic [3:0][31:0]      stage_v0, stage_v1;
    logic [ATTR_WIDTH-1:0] stage_a0, stage_a1;
    logic [6:0]            stage_oc0, stage_oc1;
    logic [6:0]            oc_in;
    logic [15:0]           culled_count;

    logic [PW:0]           wr_ptr, rd_ptr;
    logic [1:0]            rd_vidx;
    logic                  empty, full;
    logic                  accept, drop, push, cull, pop;

    logic [3:0][31:0]      mem_v [DEPTH][3];
    logic [ATTR_WIDTH-1:0] mem_a [DEPTH][3];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ready_out = !full;
    assign accept    = valid_in && ready_out;
    assign oc_in     = outcode(vertex_in);

    always_comb begin
        drop = 1'b0;
        case (mode_q)
            2'd0:    drop = 1'b0;
            2'd2:    drop = |(stage_oc0 | stage_oc1 | oc_in);
            default: drop = (|(stage_oc0 & stage_oc1 & oc_in)) ||
                            stage_oc0[6] || stage_oc1[6] || oc_in[6];
        endcase
    end

    assign push = accept && (idx == 2'd2) && !drop;
    assign cull = accept && (idx == 2'd2) && drop;
    assign pop  = valid_out && ready_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx          <= 2'd0;
            mode_q       <= 2'd0;
            stage_v0     <= '0;
            stage_v1     <= '0;
            stage_a0     <= '0;
            stage_a1     <= '0;
            stage_oc0    <= '0;
            stage_oc1    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_vidx      <= 2'd0;
            culled_count <= 16'd0;
        end else begin
            if (accept) begin
                case (idx)
                    2'd0: begin
                        stage_v0  <= vertex_in;
                        stage_a0  <= attr_in;
                        stage_oc0 <= oc_in;
                        mode_q    <= mode_in;
                        idx       <= 2'd1;
                    end
                    2'd1: begin
                        stage_v1  <= vertex_in;
                        stage_a1  <= attr_in;
                        stage_oc1 <= oc_in;
                        idx       <= 2'd2;
                    end
                    default: idx <= 2'd0;
                endcase
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (cull && (culled_count != 16'hFFFF)) culled_count <= culled_count + 16'd1;
            if (pop) begin
                if (rd_vidx == 2'd2) begin
                    rd_vidx <= 2'd0;
                    rd_ptr  <= rd_ptr + 1'b1;
                end else begin
                    rd_vidx <= rd_vidx + 2'd1;
                end
            end
        end
    end

    // Triangle storage needs no reset: nothing is visible until a slot has been written.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_v[wr_ptr[PW-1:0]][0] <= stage_v0;
            mem_v[wr_ptr[PW-1:0]][1] <= stage_v1;
            mem_v[wr_ptr[PW-1:0]][2] <= vertex_in;
            mem_a[wr_ptr[PW-1:0]][0] <= stage_a0;
            mem_a[wr_ptr[PW-1:0]][1] <= stage_a1;
            mem_a[wr_ptr[PW-1:0]][2] <= attr_in;
        end
    end

    assign valid_out        = !empty;
    assign last_out         = valid_out && (rd_vidx == 2'd2);
    assign vertex_out       = valid_out ? mem_v[rd_ptr[PW-1:0]][rd_vidx] : '0;
    assign attr_out         = valid_out ? mem_a[rd_ptr[PW-1:0]][rd_vidx] : '0;
    assign culled_count_out = culled_count;
endmodule

// File: tb/tb_frustum_cull.sv
// tb/tb_frustum_cull.sv - directed self-checking bench for frustum_cull
module tb_frustum_cull;
    localparam logic [127:0] VA  = 128'h3F800000_3F687FCC_3E5C28F6_3F25E354;
    localparam logic [127:0] VB  = 128'h3F800000_BDF3B646_3F7B22D1_BEFEF9DB;
    localparam logic [127:0] VC  = 128'h3F800000_3F7F837B_BE6147AE_3EFB7E91;
    localparam logic [127:0] VAP = 128'h3F800000_41BBEB85_3E5C28F6_3F25E354;
    localparam logic [127:0] VY  = 128'h3F800000_3F687FCC_C104C49C_3F25E354;
    localparam logic [127:0] VW  = 128'hBF800000_3F687FCC_3E5C28F6_3F25E354;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             valid_in;
    logic             ready_out;
    logic [3:0][31:0] vertex_in;
    logic [31:0]      attr_in;
    logic [1:0]       mode_in;
    logic             valid_out;
    logic             ready_in;
    logic [3:0][31:0] vertex_out;
    logic [31:0]      attr_out;
    logic             last_out;
    logic [15:0]      culled_count_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    frustum_cull #(.DEPTH(4), .ATTR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .vertex_in(vertex_in), .attr_in(attr_in), .mode_in(mode_in),
        .valid_out(valid_out), .ready_in(ready_in), .vertex_out(vertex_out),
        .attr_out(attr_out), .last_out(last_out), .culled_count_out(culled_count_out)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [127:0] v, input logic [31:0] a, input logic [1:0] m);
        int n;
        n = 0;
        valid_in  = 1'b1;
        vertex_in = v;
        attr_in   = a;
        mode_in   = m;
        while (!ready_out && n < 64) begin
            step();
            n++;
        end
        if (n == 64) check("send_ready_timeout", 128'(ready_out), 128'd1);
        step();
        valid_in = 1'b0;
        mode_in  = 2'd3;
    endtask

    task automatic tri3(input logic [127:0] v0, input logic [127:0] v1, input logic [127:0] v2,
                        input logic [31:0] a, input logic [1:0] m);
        send(v0, a, m);
        send(v1, a + 32'd1, 2'd2);
        send(v2, a + 32'd2, 2'd2);
    endtask

    function automatic logic [127:0] abc(input int k);
        return (k == 0) ? VA : (k == 1) ? VB : VC;
    endfunction

    initial begin
        rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        vertex_in = '0; attr_in = '0; mode_in = 2'd0;
        step(); step();
        rst_in = 1'b1;
        check("rst_valid_out", 128'(valid_out), 128'd0);
        check("rst_last_out", 128'(last_out), 128'd0);
        check("rst_vertex_out", 128'(vertex_out), 128'd0);
        check("rst_attr_out", 128'(attr_out), 128'd0);
        check("rst_ready_out", 128'(ready_out), 128'd1);
        check("rst_count", 128'(culled_count_out), 128'd0);

        // inside triangle, mode 2, gaps between vertices
        ready_in = 1'b1;
        send(VA, 32'h11, 2'd2); step();
        send(VB, 32'h22, 2'd2); step(); step();
        check("in_no_early_valid", 128'(valid_out), 128'd0);
        send(VC, 32'h33, 2'd2);
        check("in_v0_valid", 128'(valid_out), 128'd1);
        check("in_v0", 128'(vertex_out), VA);
        check("in_a0", 128'(attr_out), 128'h11);
        check("in_v0_last", 128'(last_out), 128'd0);
        step();
        check("in_v1", 128'(vertex_out), VB);
        check("in_v1_last", 128'(last_out), 128'd0);
        step();
        check("in_v2", 128'(vertex_out), VC);
        check("in_a2", 128'(attr_out), 128'h33);
        check("in_v2_last", 128'(last_out), 128'd1);
        step();
        check("in_drained", 128'(valid_out), 128'd0);
        check("in_count", 128'(culled_count_out), 128'd0);

        // strict drops a single z+ vertex, trivial keeps it (mode only sampled on vertex 0)
        tri3(VA, VAP, VC, 32'h40, 2'd2);
        check("strict_no_valid", 128'(valid_out), 128'd0);
        check("strict_count", 128'(culled_count_out), 128'd1);
        tri3(VA, VAP, VC, 32'h50, 2'd1);
        check("trivial_keep_v0", 128'(vertex_out), VA);
        step();
        check("trivial_keep_v1", 128'(vertex_out), VAP);
        check("trivial_keep_a1", 128'(attr_out), 128'h51);
        step();
        check("trivial_keep_v2", 128'(vertex_out), VC);
        check("trivial_keep_last", 128'(last_out), 128'd1);
        step();
        check("trivial_keep_count", 128'(culled_count_out), 128'd1);

        // trivial reject: all below y=-w, then a behind vertex, then mode 3, then mode 0 keeps
        tri3(VY, VY, VY, 32'h60, 2'd1);
        check("ty_count", 128'(culled_count_out), 128'd2);
        tri3(VA, VW, VC, 32'h70, 2'd1);
        check("behind_count", 128'(culled_count_out), 128'd3);
        check("behind_no_valid", 128'(valid_out), 128'd0);
        tri3(VY, VY, VY, 32'h80, 2'd3);
        check("mode3_count", 128'(culled_count_out), 128'd4);
        tri3(VA, VW, VC, 32'h90, 2'd0);
        check("mode0_v0", 128'(vertex_out), VA);
        step();
        check("mode0_v1", 128'(vertex_out), VW);
        step(); step();
        check("mode0_count", 128'(culled_count_out), 128'd4);
        check("mode0_drained", 128'(valid_out), 128'd0);

        // backpressure: fill four triangles, then drain twelve vertices in order
        ready_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 11) check("bp_ready_before_full", 128'(ready_out), 128'd1);
            send(abc(i % 3), 32'd100 + 32'(i), 2'd0);
        end
        check("bp_ready_full", 128'(ready_out), 128'd0);
        step(); step();
        check("bp_hold_v", 128'(vertex_out), VA);
        check("bp_hold_a", 128'(attr_out), 128'd100);
        ready_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("bp_v%0d", i), 128'(vertex_out), abc(i % 3));
            check($sformatf("bp_a%0d", i), 128'(attr_out), 128'(100 + i));
            check($sformatf("bp_last%0d", i), 128'(last_out), 128'((i % 3) == 2));
            step();
            if (i < 3) check($sformatf("bp_ready_after_pop%0d", i), 128'(ready_out), 128'(i == 2));
        end
        check("bp_drained", 128'(valid_out), 128'd0);

        // reset mid-triangle discards staging and clears the counter
        send(VA, 32'hA0, 2'd0);
        send(VB, 32'hA1, 2'd0);
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        check("mid_rst_count", 128'(culled_count_out), 128'd0);
        check("mid_rst_valid", 128'(valid_out), 128'd0);
        send(VC, 32'hB0, 2'd0);
        check("mid_rst_no_early", 128'(valid_out), 128'd0);
        send(VA, 32'hB1, 2'd0);
        send(VB, 32'hB2, 2'd0);
        check("mid_rst_v0", 128'(vertex_out), VC);
        check("mid_rst_a0", 128'(attr_out), 128'hB0);
        step();
        check("mid_rst_v1", 128'(vertex_out), VA);
        step();
        check("mid_rst_v2", 128'(vertex_out), VB);
        check("mid_rst_last", 128'(last_out), 128'd1);
        step();

        // saturation: preload near the top, then drop past it
        force dut.culled_count = 16'hFFFD;
        #1;
        release dut.culled_count;
        tri3(VA, VAP, VC, 32'hC0, 2'd2);
        check("sat_fffe", 128'(culled_count_out), 128'hFFFE);
        tri3(VA, VAP, VC, 32'hC0, 2'd2);
        check("sat_ffff", 128'(culled_count_out), 128'hFFFF);
        tri3(VA, VAP, VC, 32'hC0, 2'd2);
        check("sat_hold", 128'(culled_count_out), 128'hFFFF);
        check("sat_no_valid", 128'(valid_out), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
